// File: rtl/divider_arbiter_if.sv
// Bundle of requester, response and divider-side signals for divider_arbiter.
// slave is the arbiter's view; master is the environment (requesters plus divider).
interface divider_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_quotient;
  logic                          rsp_overflow;
  logic                          rsp_timeout;
  logic                          div_start;
  logic [DATA_WIDTH-1:0]         div_dividend;
  logic [DATA_WIDTH-1:0]         div_divisor;
  logic [DATA_WIDTH-1:0]         div_quotient;
  logic                          div_complete;
  logic                          div_overflow;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_quotient, div_complete, div_overflow,
    output req_ready, rsp_valid, rsp_quotient, rsp_overflow, rsp_timeout,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_quotient, div_complete, div_overflow,
    input  req_ready, rsp_valid, rsp_quotient, rsp_overflow, rsp_timeout,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider among NUM_REQ requesters,
// with divide-by-zero short-circuit and a completion watchdog.
module divider_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  divider_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W:0]  NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]      owner_reg, owner_next;
  logic [WD_W-1:0]       wdog_reg, wdog_next, wdog_inc;
  logic [DATA_WIDTH-1:0] dividend_reg, dividend_next;
  logic [DATA_WIDTH-1:0] divisor_reg, divisor_next;
  logic [DATA_WIDTH-1:0] quot_reg, quot_next;
  logic                  ovf_reg, ovf_next;
  logic                  tmo_reg, tmo_next;
  logic                  div_start_c;

  logic [DATA_WIDTH-1:0] dividend_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] divisor_arr  [NUM_REQ];
  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W:0]        cand;
  logic [IDX_W:0]        grant_inc;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign dividend_arr[gi]  = bus.req_dividend[gi*DATA_WIDTH +: DATA_WIDTH];
      assign divisor_arr[gi]   = bus.req_divisor[gi*DATA_WIDTH +: DATA_WIDTH];
      // Gated by rst_n so the acceptance pulse is silent while reset is held.
      assign bus.req_ready[gi] = rst_n && (state_reg == IDLE) && grant_found &&
                                 (grant_idx == IDX_W'(gi));
      assign bus.rsp_valid[gi] = (state_reg == RESP) && (owner_reg == IDX_W'(gi));
    end
  endgenerate

  // Scan from the highest rotation offset down so the lowest offset wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (bus.req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_inc = {1'b0, grant_idx} + (IDX_W + 1)'(1);
  assign wdog_inc  = wdog_reg + WD_W'(1);

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    owner_next    = owner_reg;
    wdog_next     = wdog_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    quot_next     = quot_reg;
    ovf_next      = ovf_reg;
    tmo_next      = tmo_reg;
    div_start_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          owner_next    = grant_idx;
          dividend_next = dividend_arr[grant_idx];
          divisor_next  = divisor_arr[grant_idx];
          rr_ptr_next   = (grant_inc == NUM_REQ_W) ? '0 : grant_inc[IDX_W-1:0];
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (divisor_reg != '0) begin
          div_start_c = 1'b1;
          wdog_next   = '0;
          state_next  = WAIT;
        end else begin
          quot_next  = '1;
          ovf_next   = 1'b1;
          tmo_next   = 1'b0;
          state_next = RESP;
        end
      end
      WAIT: begin
        if (bus.div_complete) begin
          quot_next  = bus.div_quotient;
          ovf_next   = bus.div_overflow;
          tmo_next   = 1'b0;
          state_next = RESP;
        end else begin
          wdog_next = wdog_inc;
          if (wdog_inc == WD_LIMIT) begin
            quot_next  = '0;
            ovf_next   = 1'b0;
            tmo_next   = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      wdog_reg     <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quot_reg     <= '0;
      ovf_reg      <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      owner_reg    <= owner_next;
      wdog_reg     <= wdog_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      quot_reg     <= quot_next;
      ovf_reg      <= ovf_next;
      tmo_reg      <= tmo_next;
    end
  end

  assign bus.div_start    = div_start_c;
  assign bus.div_dividend = dividend_reg;
  assign bus.div_divisor  = divisor_reg;
  assign bus.rsp_quotient = quot_reg;
  assign bus.rsp_overflow = ovf_reg;
  assign bus.rsp_timeout  = tmo_reg;
endmodule
